// File: rtl/blast_round_ctrl.sv
// Blast game-round sequencer: collects one shot result per player per
// round, then strobes the score unit (b1/b2/startCalc), stop and score_clr.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             start/restart request (honoured in IDLE and DONE)
//   p1_valid, p1_res  player-1 result strobe and value (3 scores as 0)
//   p2_valid, p2_res  player-2 result strobe and value (3 scores as 0)
//   b1, b2            registered results presented to the score unit
//   startCalc         one-cycle score-update strobe
//   stop              one-cycle end-of-game strobe
//   score_clr         one-cycle score clear at game start
//   round             current round index, 0-based
//   busy              high while a game is in progress
//   game_over         high once the game has finished
module blast_round_ctrl #(
  parameter int ROUNDS  = 10,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [1:0] p1_res,
  input  logic       p2_valid,
  input  logic [1:0] p2_res,
  output logic [1:0] b1,
  output logic [1:0] b2,
  output logic       startCalc,
  output logic       stop,
  output logic       score_clr,
  output logic [7:0] round,
  output logic       busy,
  output logic       game_over
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] RLAST = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CALC,
    S_STOP,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic            r_l1;
  logic            r_l2;
  logic [1:0]      r_d1;
  logic [1:0]      r_d2;

  logic            w_c1;
  logic            w_c2;
  logic [1:0]      w_v1;
  logic [1:0]      w_v2;
  logic [1:0]      w_n1;
  logic [1:0]      w_n2;
  logic            w_both;
  logic            w_tmo;
  logic            w_exit;

  // First strobe per round wins; later ones are ignored.
  assign w_c1 = p1_valid & ~r_l1;
  assign w_c2 = p2_valid & ~r_l2;

  // Code 3 is invalid and scores as a miss.
  assign w_v1 = (p1_res == 2'd3) ? 2'd0 : p1_res;
  assign w_v2 = (p2_res == 2'd3) ? 2'd0 : p2_res;

  // Value handed to the score unit includes a capture on this very edge.
  // An unlatched player holds 0 in r_dX, which is the timeout default.
  assign w_n1 = w_c1 ? w_v1 : r_d1;
  assign w_n2 = w_c2 ? w_v2 : r_d2;

  assign w_both = (r_l1 | p1_valid) & (r_l2 | p2_valid);
  assign w_tmo  = (r_timer == TLAST);
  assign w_exit = w_both | w_tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_l1      <= 1'b0;
      r_l2      <= 1'b0;
      r_d1      <= 2'd0;
      r_d2      <= 2'd0;
      b1        <= 2'd0;
      b2        <= 2'd0;
      startCalc <= 1'b0;
      stop      <= 1'b0;
      score_clr <= 1'b0;
      round     <= 8'd0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      startCalc <= 1'b0;
      stop      <= 1'b0;
      score_clr <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_COLLECT;
            score_clr <= 1'b1;
            round     <= 8'd0;
            r_timer   <= '0;
            r_l1      <= 1'b0;
            r_l2      <= 1'b0;
            r_d1      <= 2'd0;
            r_d2      <= 2'd0;
            busy      <= 1'b1;
            game_over <= 1'b0;
          end
        end
        S_COLLECT: begin
          r_timer <= r_timer + 1'b1;
          if (w_c1) begin
            r_l1 <= 1'b1;
            r_d1 <= w_v1;
          end
          if (w_c2) begin
            r_l2 <= 1'b1;
            r_d2 <= w_v2;
          end
          if (w_exit) begin
            r_state   <= S_CALC;
            b1        <= w_n1;
            b2        <= w_n2;
            startCalc <= 1'b1;
          end
        end
        S_CALC: begin
          if (round == RLAST) begin
            r_state <= S_STOP;
            stop    <= 1'b1;
          end else begin
            r_state <= S_COLLECT;
            round   <= round + 8'd1;
            r_timer <= '0;
            r_l1    <= 1'b0;
            r_l2    <= 1'b0;
            r_d1    <= 2'd0;
            r_d2    <= 2'd0;
          end
        end
        S_STOP: begin
          r_state   <= S_DONE;
          busy      <= 1'b0;
          game_over <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
